zjh_scan_decoder: RTL and testbench

//  Parametrised, registered successor to the team's 3-to-8 line decoder: SEL_W-to-2^SEL_W

---
 rtl/zjh_dec_pkg.sv | 24 ++
 rtl/zjh_scan_decoder_if.sv | 28 ++
 rtl/zjh_dwell_timer.sv | 43 ++++
 rtl/zjh_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_zjh_scan_decoder.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/zjh_dec_pkg.sv
// Shared types and decode helper for the scanning line decoder.
package zjh_dec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDirect,
    StScan,
    StBlank
  } dec_state_e;

  localparam logic [2:0]  EN_OK     = 3'b100;
  localparam int unsigned MAX_SEL_W = 6;
  localparam int unsigned MAX_OUT_N = 64;

  // Widest decode; callers truncate to their own output count.
  function automatic logic [MAX_OUT_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                  input logic                 pol);
    logic [MAX_OUT_N-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return pol ? ~v : v;
  endfunction

endpackage

// File: rtl/zjh_scan_decoder_if.sv
// Control inputs and decoded outputs of the scanning line decoder.
interface zjh_scan_decoder_if #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 16
) ();

  localparam int unsigned OUT_N = 2 ** SEL_W;

  logic [2:0]         e;
  logic               mode;
  logic [SEL_W-1:0]   a;
  logic [DWELL_W-1:0] dwell_i;
  logic [OUT_N-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               active;
  logic               wrap;

  modport master (
    output e, mode, a, dwell_i,
    input  y, idx, active, wrap
  );

  modport slave (
    input  e, mode, a, dwell_i,
    output y, idx, active, wrap
  );

endinterface

// File: rtl/zjh_dwell_timer.sv
// Loadable down-counter with freeze; used for both dwell and blanking intervals.
module zjh_dwell_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         freeze_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (load_i) begin
        cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Zero doubles as "no interval in progress"; one marks the last cycle of an interval.
  assign zero_o = (cnt_q == '0);
  assign tc_o   = (cnt_q == W'(1));

endmodule

// File: rtl/zjh_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W decoder with three-enable gating and an auto-scan mode
// that walks the outputs with a programmable dwell and blanking gap.
module zjh_scan_decoder
  import zjh_dec_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned OUT_N      = 2 ** SEL_W,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned DWELL_W    = 16,
  parameter int unsigned BLANK_CYC  = 1
) (
  input logic               clk,
  input logic               rst_n,
  zjh_scan_decoder_if.slave bus
);

  localparam logic [OUT_N-1:0] YInactive = ACTIVE_LOW ? {OUT_N{1'b1}} : '0;

  function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] sel);
    return OUT_N'(onehot(MAX_SEL_W'(sel), ACTIVE_LOW));
  endfunction

  dec_state_e       state_d, state_q;
  logic [SEL_W-1:0] sidx_d, sidx_q;
  logic [SEL_W-1:0] idx_d, idx_q;
  logic [OUT_N-1:0] y_d, y_q;
  logic             active_d, active_q;
  logic             wrap_d, wrap_q;

  logic               e_ok;
  logic [DWELL_W-1:0] dwell_ld;
  logic [SEL_W-1:0]   sidx_nxt;
  logic               step;

  logic dw_clr, dw_load, dw_dec, dw_zero, dw_tc;
  logic bk_clr, bk_load, bk_dec, bk_zero, bk_tc;

  assign e_ok     = (bus.e == EN_OK);
  assign dwell_ld = (bus.dwell_i == '0) ? DWELL_W'(1) : bus.dwell_i;
  assign sidx_nxt = sidx_q + 1'b1;

  zjh_dwell_timer #(
    .W (DWELL_W)
  ) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .freeze_i   (~e_ok),
    .clr_i      (dw_clr),
    .load_i     (dw_load),
    .load_val_i (dwell_ld),
    .dec_i      (dw_dec),
    .zero_o     (dw_zero),
    .tc_o       (dw_tc)
  );

  zjh_dwell_timer #(
    .W (DWELL_W)
  ) u_blank (
    .clk        (clk),
    .rst_n      (rst_n),
    .freeze_i   (~e_ok),
    .clr_i      (bk_clr),
    .load_i     (bk_load),
    .load_val_i (DWELL_W'(BLANK_CYC)),
    .dec_i      (bk_dec),
    .zero_o     (bk_zero),
    .tc_o       (bk_tc)
  );

  always_comb begin
    state_d  = state_q;
    sidx_d   = sidx_q;
    idx_d    = idx_q;
    y_d      = YInactive;
    active_d = 1'b0;
    wrap_d   = 1'b0;
    step     = 1'b0;
    dw_clr   = 1'b0;
    dw_load  = 1'b0;
    dw_dec   = 1'b0;
    bk_clr   = 1'b0;
    bk_load  = 1'b0;
    bk_dec   = 1'b0;

    if (!e_ok) begin
      // Scan position and both timers hold, so a re-enable resumes where it stopped.
      state_d = StIdle;
    end else if (!bus.mode) begin
      state_d  = StDirect;
      y_d      = decode(bus.a);
      active_d = 1'b1;
      idx_d    = bus.a;
      sidx_d   = '0;
      dw_clr   = 1'b1;
      bk_clr   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDirect: begin
          if (!bk_zero) begin
            state_d = StBlank;
          end else begin
            state_d  = StScan;
            dw_load  = dw_zero;
            y_d      = decode(sidx_q);
            active_d = 1'b1;
            idx_d    = sidx_q;
          end
        end
        StScan: begin
          if (!dw_tc) begin
            dw_dec   = 1'b1;
            y_d      = decode(sidx_q);
            active_d = 1'b1;
            idx_d    = sidx_q;
          end else if (BLANK_CYC != 0) begin
            dw_clr  = 1'b1;
            bk_load = 1'b1;
            state_d = StBlank;
          end else begin
            step = 1'b1;
          end
        end
        StBlank: begin
          if (!bk_tc) begin
            bk_dec = 1'b1;
          end else begin
            bk_clr = 1'b1;
            step   = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (step) begin
      state_d  = StScan;
      dw_load  = 1'b1;
      sidx_d   = sidx_nxt;
      idx_d    = sidx_nxt;
      y_d      = decode(sidx_nxt);
      active_d = 1'b1;
      wrap_d   = (sidx_q == {SEL_W{1'b1}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sidx_q   <= '0;
      idx_q    <= '0;
      y_q      <= YInactive;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sidx_q   <= sidx_d;
      idx_q    <= idx_d;
      y_q      <= y_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.y      = y_q;
  assign bus.idx    = idx_q;
  assign bus.active = active_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_zjh_scan_decoder.sv
// Bench for zjh_scan_decoder: three configurations checked every cycle against a
// behavioural model, plus hand-computed expectations for the key scenarios.
module tb_zjh_scan_decoder;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic [2:0]  e_s     = 3'b000;
  logic        mode_s  = 1'b0;
  logic [3:0]  a_s     = 4'd0;
  logic [15:0] dwell_s = 16'd3;
  int          n_pass  = 0;
  int          n_total = 0;
  bit          chk_en  = 1'b0;

  always #5 clk = ~clk;

  zjh_scan_decoder_if #(.SEL_W(3), .DWELL_W(16)) if0 ();
  zjh_scan_decoder_if #(.SEL_W(3), .DWELL_W(16)) if1 ();
  zjh_scan_decoder_if #(.SEL_W(4), .DWELL_W(16)) if2 ();

  assign if0.e = e_s;   assign if0.mode = mode_s; assign if0.a = a_s[2:0]; assign if0.dwell_i = dwell_s;
  assign if1.e = e_s;   assign if1.mode = mode_s; assign if1.a = a_s[2:0]; assign if1.dwell_i = dwell_s;
  assign if2.e = e_s;   assign if2.mode = mode_s; assign if2.a = a_s;      assign if2.dwell_i = dwell_s;

  zjh_scan_decoder #(.SEL_W(3), .ACTIVE_LOW(1'b1), .DWELL_W(16), .BLANK_CYC(1)) u_d0 (
    .clk (clk), .rst_n (rst_n), .bus (if0)
  );
  zjh_scan_decoder #(.SEL_W(3), .ACTIVE_LOW(1'b1), .DWELL_W(16), .BLANK_CYC(0)) u_d1 (
    .clk (clk), .rst_n (rst_n), .bus (if1)
  );
  zjh_scan_decoder #(.SEL_W(4), .ACTIVE_LOW(1'b0), .DWELL_W(16), .BLANK_CYC(2)) u_d2 (
    .clk (clk), .rst_n (rst_n), .bus (if2)
  );

  // ---------------- behavioural model ----------------
  localparam int MIdle = 0, MDirect = 1, MScan = 2, MBlank = 3;

  typedef struct {
    int st;     // behaviour being shown
    int pos;    // scan position
    int left;   // cycles still to show at pos (0: none pending)
    int bleft;  // blank cycles still to go
    int lit;    // index lit this cycle, -1 if none
    int idx;
    bit wrap;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = MIdle; r.pos = 0; r.left = 0; r.bleft = 0; r.lit = -1; r.idx = 0; r.wrap = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [2:0] e, logic mode, int a, int dwell, int n,
                                 int blank);
    mdl_t r;
    bit   adv;
    r = m; r.wrap = 1'b0; adv = 1'b0;
    if (e != 3'b100) begin
      r.st = MIdle; r.lit = -1;
    end else if (!mode) begin
      r.st = MDirect; r.lit = a; r.idx = a; r.pos = 0; r.left = 0; r.bleft = 0;
    end else if (m.st == MIdle || m.st == MDirect) begin
      if (m.bleft > 0) begin
        r.st = MBlank; r.lit = -1;
      end else begin
        r.st = MScan;
        if (m.left == 0) r.left = (dwell == 0) ? 1 : dwell;
        r.lit = m.pos; r.idx = m.pos;
      end
    end else if (m.st == MScan) begin
      if (m.left > 1) begin
        r.left = m.left - 1; r.lit = m.pos; r.idx = m.pos;
      end else if (blank > 0) begin
        r.left = 0; r.st = MBlank; r.bleft = blank; r.lit = -1;
      end else begin
        adv = 1'b1;
      end
    end else begin
      r.lit = -1;
      if (m.bleft > 1) r.bleft = m.bleft - 1;
      else begin r.bleft = 0; adv = 1'b1; end
    end
    if (adv) begin
      r.pos  = (m.pos + 1) % n;
      r.wrap = (r.pos == 0);
      r.left = (dwell == 0) ? 1 : dwell;
      r.st   = MScan; r.lit = r.pos; r.idx = r.pos;
    end
    return r;
  endfunction

  function automatic logic [63:0] dpack(logic w, logic act, logic [7:0] idx, logic [63:0] y);
    return (64'(w) << 40) | (64'(act) << 32) | (64'(idx) << 24) | y;
  endfunction

  function automatic logic [63:0] mexp(mdl_t m, int n, bit al);
    logic [63:0] mask, oh, y;
    mask = (64'd1 << n) - 64'd1;
    oh   = (m.lit < 0) ? 64'd0 : (64'd1 << m.lit);
    y    = al ? (~oh & mask) : oh;
    return dpack(m.wrap, m.lit >= 0, 8'(m.idx), y);
  endfunction

  mdl_t m0, m1, m2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 = mreset(); m1 = mreset(); m2 = mreset();
    end else begin
      m0 = mstep(m0, e_s, mode_s, int'(a_s[2:0]), int'(dwell_s), 8, 1);
      m1 = mstep(m1, e_s, mode_s, int'(a_s[2:0]), int'(dwell_s), 8, 0);
      m2 = mstep(m2, e_s, mode_s, int'(a_s), int'(dwell_s), 16, 2);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("d0_cycle", dpack(if0.wrap, if0.active, 8'(if0.idx), 64'(if0.y)), mexp(m0, 8, 1'b1));
      check("d1_cycle", dpack(if1.wrap, if1.active, 8'(if1.idx), 64'(if1.y)), mexp(m1, 8, 1'b1));
      check("d2_cycle", dpack(if2.wrap, if2.active, 8'(if2.idx), 64'(if2.y)), mexp(m2, 16, 1'b0));
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int         wraps;
    int         first_wrap;
    bit         found;
    logic [7:0] exp8;
    logic [2:0] bad_e[3];
    logic [7:0] resume_seq[4];

    bad_e      = '{3'b000, 3'b110, 3'b101};
    resume_seq = '{8'hEF, 8'hEF, 8'hFF, 8'hDF};

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #2;
    check("reset_y", 64'(if0.y), 64'hFF);
    check("reset_idx", 64'(if0.idx), 64'd0);
    check("reset_active", 64'(if0.active), 64'd0);
    check("reset_y_d2", 64'(if2.y), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // direct decode
    @(negedge clk);
    e_s = 3'b100; mode_s = 1'b0; a_s = 4'd5;
    @(negedge clk);
    check("direct_y", 64'(if0.y), 64'hDF);
    check("direct_idx", 64'(if0.idx), 64'd5);
    check("direct_active", 64'(if0.active), 64'd1);

    // enable gating
    for (int i = 0; i < 3; i++) begin
      e_s = bad_e[i]; a_s = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("gate_y", 64'(if0.y), 64'hFF);
      check("gate_active", 64'(if0.active), 64'd0);
    end

    // scan, dwell 3, one blank cycle: 32-cycle period
    e_s = 3'b100; mode_s = 1'b1; dwell_s = 16'd3;
    wraps = 0; first_wrap = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      exp8 = ((k % 4) == 3) ? 8'hFF : (8'hFF ^ (8'd1 << ((k / 4) % 8)));
      check("scan_y", 64'(if0.y), 64'(exp8));
      if (if0.wrap) begin
        wraps++;
        if (first_wrap < 0) first_wrap = k;
      end
    end
    check("scan_wrap_count", 64'(wraps), 64'd1);
    check("scan_wrap_pos", 64'(first_wrap), 64'd32);
    for (int k = 64; k < 82; k++) begin
      @(negedge clk);
      exp8 = ((k % 4) == 3) ? 8'hFF : (8'hFF ^ (8'd1 << ((k / 4) % 8)));
      check("scan_y", 64'(if0.y), 64'(exp8));
    end
    check("freeze_pre_idx", 64'(if0.idx), 64'd4);

    // freeze at idx 4 with two dwell cycles left
    e_s = 3'b000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("freeze_y", 64'(if0.y), 64'hFF);
    end
    e_s = 3'b100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("resume_y", 64'(if0.y), 64'(resume_seq[k]));
    end

    // mode 1->0 mid-scan, then back to scan from idx 0
    mode_s = 1'b0; a_s = 4'd3;
    @(negedge clk);
    check("m10_y", 64'(if0.y), 64'hF7);
    check("m10_idx", 64'(if0.idx), 64'd3);
    mode_s = 1'b1;
    @(negedge clk);
    check("m01_y", 64'(if0.y), 64'hFE);
    check("m01_idx", 64'(if0.idx), 64'd0);
    e_s = 3'b000; mode_s = 1'b0;
    @(negedge clk);
    check("e_priority_y", 64'(if0.y), 64'hFF);

    // dwell 0, no blanking: one step per cycle
    e_s = 3'b100; mode_s = 1'b0; a_s = 4'd0;
    @(negedge clk);
    mode_s = 1'b1; dwell_s = 16'd0;
    wraps = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check("fast_idx", 64'(if1.idx), 64'(k % 8));
      if (if1.wrap) wraps++;
    end
    check("fast_wraps", 64'(wraps), 64'd2);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      e_s     = ($urandom_range(0, 9) < 8) ? 3'b100 : 3'($urandom_range(0, 7));
      mode_s  = ($urandom_range(0, 19) != 0);
      a_s     = 4'($urandom_range(0, 15));
      dwell_s = 16'($urandom_range(0, 4));
      @(negedge clk);
    end

    // async reset while showing idx 6
    e_s = 3'b100; mode_s = 1'b1; dwell_s = 16'd2;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (if0.idx == 3'd6 && if0.active) found = 1'b1;
    end
    check("reach_idx6", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_y", 64'(if0.y), 64'hFF);
    check("areset_idx", 64'(if0.idx), 64'd0);
    check("areset_wrap", 64'(if0.wrap), 64'd0);
    check("areset_y_d2", 64'(if2.y), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 16-output active-high instance
    e_s = 3'b100; mode_s = 1'b0; a_s = 4'd9;
    @(negedge clk);
    check("p16_direct_y", 64'(if2.y), 64'h0200);
    check("p16_direct_idx", 64'(if2.idx), 64'd9);
    check("d0_direct_a9_y", 64'(if0.y), 64'hFD);
    mode_s = 1'b1; dwell_s = 16'd1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      check("p16_scan_y", 64'(if2.y), ((k % 3) == 0) ? (64'd1 << (k / 3)) : 64'd0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
